// File: rtl/reg_bank.sv
// Multi-port register bank: two combinational tri-state read ports, one byte-enabled write port,
// optional hardwired zero entry, optional write-to-read bypass, and a sequenced bulk-clear engine.
module reg_bank #(
  parameter int               WIDTH      = 32,
  parameter int               DEPTH      = 32,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0,
  parameter bit               ZERO_REG   = 1'b1,
  parameter bit               BYPASS     = 1'b1,
  localparam int              AW         = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wEna,
  input  logic [AW-1:0]      wAddr,
  input  logic [WIDTH/8-1:0] wByteEna,
  input  logic [WIDTH-1:0]   iData,
  input  logic [AW-1:0]      rAddrA,
  input  logic [AW-1:0]      rAddrB,
  input  logic               rEnaA,
  input  logic               rEnaB,
  output logic [WIDTH-1:0]   oDataA,
  output logic [WIDTH-1:0]   oDataB,
  input  logic               clrReq,
  output logic               busy,
  output logic               wDrop
);

  localparam int            NB   = WIDTH / 8;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t             state, state_nxt;
  logic [AW-1:0]      ptr, ptr_nxt;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic               wr_ok;
  logic [WIDTH-1:0]   rd_a, rd_b;

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old_val,
                                             input logic [WIDTH-1:0] new_val,
                                             input logic [NB-1:0]    be);
    logic [WIDTH-1:0] res;
    res = old_val;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  // User writes are only taken while the clear engine is idle; entry 0 is read-only when hardwired.
  assign wr_ok = wEna && (state == IDLE) && !(ZERO_REG && (wAddr == '0));
  assign busy  = (state == CLEAR);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    unique case (state)
      IDLE: begin
        if (clrReq) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end
      end
      CLEAR: begin
        if (ptr == LAST) begin
          state_nxt = IDLE;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = ptr + AW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= '0;
      wDrop <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      wDrop <= (state == CLEAR) && wEna && (|wByteEna);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= INIT_VALUE;
    end else if (state == CLEAR) begin
      mem[ptr] <= INIT_VALUE;
    end else if (wr_ok) begin
      mem[wAddr] <= merge(mem[wAddr], iData, wByteEna);
    end
  end

  // Clear writes are never forwarded: wr_ok is already low during CLEAR.
  always_comb begin
    rd_a = mem[rAddrA];
    rd_b = mem[rAddrB];
    if (BYPASS && wr_ok && (rAddrA == wAddr)) rd_a = merge(rd_a, iData, wByteEna);
    if (BYPASS && wr_ok && (rAddrB == wAddr)) rd_b = merge(rd_b, iData, wByteEna);
    if (ZERO_REG && (rAddrA == '0)) rd_a = '0;
    if (ZERO_REG && (rAddrB == '0)) rd_b = '0;
  end

  assign oDataA = rEnaA ? rd_a : {WIDTH{1'bz}};
  assign oDataB = rEnaB ? rd_b : {WIDTH{1'bz}};

endmodule

// File: tb/tb_reg_bank.sv
// Randomised self-checking bench for reg_bank against an array/counter reference model.
module tb_reg_bank;
  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 5;
  localparam int NB = W / 8;
  localparam logic [W-1:0] INIT = '0;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wEna = 1'b0;
  logic [AW-1:0] wAddr = '0;
  logic [NB-1:0] wByteEna = '0;
  logic [W-1:0]  iData = '0;
  logic [AW-1:0] rAddrA = '0, rAddrB = '0;
  logic          rEnaA = 1'b1, rEnaB = 1'b1;
  logic          clrReq = 1'b0;
  wire  [W-1:0]  oDataA, oDataB;
  wire           busy, wDrop;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] model [D];
  int           clr_left = 0;
  logic         exp_drop = 1'b0;

  reg_bank #(.WIDTH(W), .DEPTH(D), .INIT_VALUE(INIT), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .wEna(wEna), .wAddr(wAddr), .wByteEna(wByteEna), .iData(iData),
    .rAddrA(rAddrA), .rAddrB(rAddrB), .rEnaA(rEnaA), .rEnaB(rEnaB),
    .oDataA(oDataA), .oDataB(oDataB), .clrReq(clrReq), .busy(busy), .wDrop(wDrop)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  function automatic logic [W-1:0] merge(input logic [W-1:0] o, input logic [W-1:0] n,
                                         input logic [NB-1:0] be);
    logic [W-1:0] r;
    r = o;
    for (int i = 0; i < NB; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  // Expected read value given the current (pre-edge) inputs and model.
  function automatic logic [W-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (clr_left == 0 && wEna && wAddr == a) return merge(model[a], iData, wByteEna);
    return model[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) model[i] = INIT;
    clr_left = 0;
    exp_drop = 1'b0;
  endtask

  // Advance the model by one clock edge, then the DUT, and settle 1 time unit after the edge.
  task automatic tick();
    logic drop;
    drop = (clr_left > 0) && wEna && (|wByteEna);
    if (clr_left > 0) begin
      model[D - clr_left] = INIT;
      clr_left--;
    end else begin
      if (wEna && wAddr != 0) model[wAddr] = merge(model[wAddr], iData, wByteEna);
      if (clrReq) clr_left = D;
    end
    @(posedge clk);
    #1;
    exp_drop = drop;
  endtask

  task automatic idle_inputs();
    wEna = 0; clrReq = 0; wByteEna = '0; rEnaA = 1; rEnaB = 1;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [NB-1:0] be);
    wEna = 1; wAddr = a; iData = d; wByteEna = be;
    tick();
    wEna = 0;
  endtask

  task automatic test_reset();
    model_reset();
    idle_inputs();
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (wDrop !== 1'b0) begin bad++; $display("FAIL reset_wdrop got=%b want=0", wDrop); end
    for (int i = 0; i < 4; i++) begin
      rAddrA = AW'($urandom_range(1, D-1));
      #1;
      total++;
      if (oDataA !== INIT) begin bad++; $display("FAIL reset_entry a=%0d got=%h want=%h", rAddrA, oDataA, INIT); end
    end
    rst = 1;
    #1;
  endtask

  task automatic test_full_write();
    write(5, 32'hDEADBEEF, 4'hF);
    rAddrA = 5; rAddrB = 6;
    #1;
    total++; if (oDataA !== 32'hDEADBEEF) begin bad++; $display("FAIL full_write got=%h want=deadbeef", oDataA); end
    total++; if (oDataB !== INIT) begin bad++; $display("FAIL neighbour got=%h want=%h", oDataB, INIT); end
  endtask

  task automatic test_byte_lanes();
    write(5, 32'h11223344, 4'b0101);
    rAddrA = 5;
    #1;
    total++; if (oDataA !== 32'hDE22BE44) begin bad++; $display("FAIL byte_lanes got=%h want=de22be44", oDataA); end
    write(5, 32'h99999999, 4'b0000);
    #1;
    total++; if (oDataA !== 32'hDE22BE44 || wDrop !== 1'b0) begin bad++; $display("FAIL be_zero got=%h drop=%b want=de22be44 drop=0", oDataA, wDrop); end
    for (int n = 0; n < 40; n++) begin
      write(AW'($urandom_range(1, D-1)), $urandom, NB'($urandom));
      rAddrA = AW'($urandom); rAddrB = AW'($urandom);
      #1;
      total++;
      if (oDataA !== exp_rd(rAddrA) || oDataB !== exp_rd(rAddrB)) begin
        bad++;
        $display("FAIL rand_lanes a=%0d got=%h want=%h b=%0d got=%h want=%h",
                 rAddrA, oDataA, exp_rd(rAddrA), rAddrB, oDataB, exp_rd(rAddrB));
      end
    end
  endtask

  task automatic test_zero_tristate();
    write(0, 32'hFFFFFFFF, 4'hF);
    rAddrA = 0; rAddrB = 5; rEnaB = 0;
    #1;
    total++; if (oDataA !== 32'h0) begin bad++; $display("FAIL zero_reg got=%h want=0", oDataA); end
    // Undriven bus reads as z, or as 0 in a two-state simulator; entry 5 is nonzero so either detects leakage.
    total++;
    if (oDataB !== {W{1'bz}} && oDataB !== '0) begin bad++; $display("FAIL tristate got=%h want=z model=%h", oDataB, model[5]); end
    rEnaB = 1;
    #1;
    total++; if (oDataB !== model[5]) begin bad++; $display("FAIL reenable got=%h want=%h", oDataB, model[5]); end
  endtask

  task automatic test_bypass();
    logic [W-1:0] old7;
    old7 = model[7];
    wEna = 1; wAddr = 7; iData = 32'hA5A5A5A5; wByteEna = 4'hF; rAddrA = 7; rAddrB = 8;
    #1;
    total++; if (oDataA !== 32'hA5A5A5A5) begin bad++; $display("FAIL bypass got=%h want=a5a5a5a5 old=%h", oDataA, old7); end
    total++; if (oDataB !== model[8]) begin bad++; $display("FAIL bypass_other got=%h want=%h", oDataB, model[8]); end
    tick(); wEna = 0;
    #1;
    total++; if (oDataA !== 32'hA5A5A5A5) begin bad++; $display("FAIL bypass_after got=%h want=a5a5a5a5", oDataA); end
    wEna = 1; wAddr = 0; iData = 32'h12345678; rAddrA = 0;
    #1;
    total++; if (oDataA !== 32'h0) begin bad++; $display("FAIL bypass_zero got=%h want=0", oDataA); end
    wEna = 0;
    for (int n = 0; n < 30; n++) begin
      wEna = 1; wAddr = AW'($urandom); iData = $urandom; wByteEna = NB'($urandom);
      rAddrA = wAddr; rAddrB = AW'($urandom);
      #1;
      total++;
      if (oDataA !== exp_rd(rAddrA) || oDataB !== exp_rd(rAddrB)) begin
        bad++;
        $display("FAIL rand_bypass a=%0d got=%h want=%h b=%0d got=%h want=%h",
                 rAddrA, oDataA, exp_rd(rAddrA), rAddrB, oDataB, exp_rd(rAddrB));
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_bulk_clear();
    int n;
    for (int i = 1; i < D; i++) write(AW'(i), W'(i), 4'hF);
    clrReq = 1;
    tick();
    clrReq = 0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      total++; if (wDrop !== exp_drop) begin bad++; $display("FAIL clr_wdrop cyc=%0d got=%b want=%b", n, wDrop, exp_drop); end
      if (n == 11) begin wEna = 1; wAddr = 3; iData = 32'hCAFEF00D; wByteEna = 4'hF; end
      if (n == 16) clrReq = 1;
      if (n == 21) begin
        rAddrA = 19; rAddrB = 20;
        #1;
        total++;
        if (oDataA !== exp_rd(19) || oDataB !== exp_rd(20)) begin
          bad++; $display("FAIL clr_ptr_read got=%h,%h want=%h,%h", oDataA, oDataB, exp_rd(19), exp_rd(20));
        end
      end
      tick();
      wEna = 0; clrReq = 0;
      if (n == 11) begin
        total++; if (wDrop !== 1'b1) begin bad++; $display("FAIL drop_pulse got=%b want=1", wDrop); end
      end
    end
    total++; if (n != D) begin bad++; $display("FAIL busy_len got=%0d want=%0d", n, D); end
    total++; if (wDrop !== 1'b0) begin bad++; $display("FAIL drop_after got=%b want=0", wDrop); end
    for (int i = 0; i < D; i++) begin
      rAddrA = AW'(i);
      #1;
      total++; if (oDataA !== INIT || model[i] !== INIT) begin bad++; $display("FAIL cleared e=%0d got=%h want=%h", i, oDataA, INIT); end
    end
    write(4, 32'h0BADF00D, 4'hF);
    rAddrA = 4;
    #1;
    total++; if (oDataA !== 32'h0BADF00D) begin bad++; $display("FAIL post_clear_write got=%h want=0badf00d", oDataA); end
  endtask

  task automatic test_reset_mid_clear();
    wEna = 1; wAddr = 12; iData = 32'h5A5A1234; wByteEna = 4'hF; clrReq = 1;
    tick();
    wEna = 0; clrReq = 0;
    rAddrA = 12;
    #1;
    total++; if (busy !== 1'b1 || oDataA !== 32'h5A5A1234) begin bad++; $display("FAIL collide busy=%b got=%h want=1,5a5a1234", busy, oDataA); end
    repeat (9) tick();
    wEna = 1; wAddr = 20; iData = 32'h1; wByteEna = 4'h1;
    tick();
    wEna = 0;
    total++; if (wDrop !== 1'b1) begin bad++; $display("FAIL pre_reset_drop got=%b want=1", wDrop); end
    #2;
    rst = 0;
    model_reset();
    #1;
    total++; if (busy !== 1'b0 || wDrop !== 1'b0) begin bad++; $display("FAIL async_reset busy=%b drop=%b want=0,0", busy, wDrop); end
    for (int i = 0; i < D; i++) begin
      rAddrA = AW'(i);
      #1;
      total++; if (oDataA !== INIT) begin bad++; $display("FAIL reset_clear e=%0d got=%h want=%h", i, oDataA, INIT); end
    end
    @(negedge clk);
    rst = 1;
    write(12, 32'h77665544, 4'hF);
    rAddrA = 12;
    #1;
    total++; if (oDataA !== 32'h77665544 || wDrop !== 1'b0) begin bad++; $display("FAIL post_reset got=%h drop=%b want=77665544,0", oDataA, wDrop); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      wEna = ($urandom_range(0, 2) != 0); wAddr = AW'($urandom); iData = $urandom;
      wByteEna = NB'($urandom); clrReq = ($urandom_range(0, 60) == 0);
      rAddrA = AW'($urandom); rAddrB = ($urandom_range(0, 1) != 0) ? wAddr : AW'($urandom);
      rEnaA = ($urandom_range(0, 7) != 0); rEnaB = 1;
      #1;
      total++;
      if ((rEnaA && oDataA !== exp_rd(rAddrA)) || oDataB !== exp_rd(rAddrB)) begin
        bad++;
        $display("FAIL rand_read n=%0d a=%0d got=%h want=%h b=%0d got=%h want=%h",
                 n, rAddrA, oDataA, exp_rd(rAddrA), rAddrB, oDataB, exp_rd(rAddrB));
      end
      tick();
      total++;
      if (busy !== (clr_left > 0) || wDrop !== exp_drop) begin
        bad++; $display("FAIL rand_ctl n=%0d busy=%b drop=%b want=%b,%b", n, busy, wDrop, clr_left > 0, exp_drop);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_full_write();
    test_byte_lanes();
    test_zero_tristate();
    test_bypass();
    test_bulk_clear();
    test_reset_mid_clear();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_bank.md
# reg_bank

Parametrised multi-port register bank for the multicycle datapath; generalises the single enable-gated 32-bit register into DEPTH entries of WIDTH bits. It provides two tri-state read ports, one write port with byte enables, an optional hardwired zero entry, and optional write-to-read bypass. A sequenced bulk-clear engine walks every entry back to INIT_VALUE. It serves as the general-purpose register file and as a bank of CP0/scratch registers.

## Interface
- WIDTH, 32, entry width in bits; multiple of 8.
- DEPTH, 32, number of entries; power of two, ≥2.
- AW, $clog2(DEPTH), address width; derived, not overridden.
- INIT_VALUE, 32'b0, value loaded by reset and by bulk clear (WIDTH bits).
- ZERO_REG, 1, 1: entry 0 always reads 0 and ignores writes.
- BYPASS, 1, 1: same-cycle write data is forwarded to a matching read port.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- wEna  in  1  write request.
- wAddr  in  AW  write address.
- wByteEna  in  WIDTH/8  byte lane enables; bit i covers iData[8i+7:8i].
- iData  in  WIDTH  write data.
- rAddrA / rAddrB  in  AW  read addresses.
- rEnaA / rEnaB  in  1  output enables; 0 drives the port to high-Z.
- oDataA / oDataB  out  WIDTH  read data.
- clrReq  in  1  bulk-clear request, one-cycle pulse or level.
- busy  out  1  high while bulk clear is in progress.
- wDrop  out  1  one-cycle pulse: a user write was discarded.

## Operation
- Storage: DEPTH×WIDTH flops. Reset (rst=0) sets every entry to INIT_VALUE, FSM to IDLE, clear pointer to 0, busy=0, wDrop=0.
- Write: at a rising edge with wEna=1, FSM=IDLE, and not (ZERO_REG and wAddr==0), each byte lane with wByteEna[i]=1 is updated; other lanes hold. wByteEna==0 is a no-op and is not a drop.
- Read: combinational from the array. With ZERO_REG=1, address 0 returns 0 regardless of contents. With rEna=0, the port is 'z.
- Bypass (BYPASS=1): if wEna and the write is accepted this cycle and rAddrX==wAddr, oDataX = merge(array entry, iData, wByteEna). With BYPASS=0, the old value is shown until after the edge. The zero entry is never bypassed.
- Clear FSM states: IDLE, CLEAR.
  - IDLE→CLEAR on clrReq=1; ptr←0.
  - CLEAR: each edge writes INIT_VALUE to entry ptr (all lanes) and increments ptr.
  - At ptr==DEPTH-1, the final write occurs and the FSM goes to IDLE, ptr←0.
  - busy = (state==CLEAR).
- During CLEAR, wEna=1 writes are discarded and wDrop pulses in the following cycle. clrReq during CLEAR is ignored; clearing does not restart.
- clrReq and wEna both in IDLE in the same cycle: the write is performed, CLEAR starts next cycle, and the written entry is later cleared.
- Clear writes are never bypassed. Reading entry ptr during its clear cycle returns the old value.
- ptr wraps only via the terminal transition, never by overflow.

## Timing
- Write latency: data is visible on read ports one cycle after the accepting edge, or same cycle combinationally when BYPASS=1.
- Read latency: 0 cycles (combinational on address/enable).
- Bulk clear: busy rises 1 edge after clrReq and stays high exactly DEPTH cycles. The first user write accepted is at the edge where busy is sampled 0.
- wDrop: registered, high for exactly one cycle per dropped write.
- Reset mid-CLEAR: immediate asynchronous return to IDLE with all entries at INIT_VALUE. busy and wDrop fall without waiting for a clock.
- Reset release: first write accepted at the first rising edge with rst=1.

## Test plan
- Reset then full-word write: rst low→high, write 0xDEADBEEF to entry 5 with wByteEna=4'hF. Next cycle rAddrA=5 reads 0xDEADBEEF; rAddrB=6 reads INIT_VALUE.
- Byte lanes: entry 5=0xDEADBEEF, write iData=0x11223344 with wByteEna=4'b0101. Entry reads 0xDE22BE44.
- Zero register and tri-state: write 0xFFFFFFFF to entry 0. oDataA at addr 0 reads 0x00000000; rEnaB=0 gives oDataB all 'z.
- Bypass: same cycle wEna=1, wAddr=7, iData=0xA5A5A5A5, rAddrA=7. BYPASS=1 gives oDataA=0xA5A5A5A5 before the edge; BYPASS=0 gives the old value, then the new value after the edge.
- Bulk clear: fill all entries with their index, pulse clrReq.
  - busy is high DEPTH cycles.
  - A write to entry 3 mid-clear is dropped and wDrop pulses once.
  - After busy falls, all entries read INIT_VALUE.
  - A second clrReq mid-clear has no effect on duration.
- Reset mid-clear: assert rst at ptr=10. busy=0 and all entries read INIT_VALUE immediately. After release, a write to entry 12 succeeds with wDrop=0.
